// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RV32I main control FSM
//
// Sequences FETCH -> DECODE -> EXEC -> [MEM] -> [WB] for the RV32I base
// opcodes and traps permanently on any illegal opcode.
//
// Configuration macro: MCC_MEM_WAIT_EN
//   defined   : FETCH/MEM hold their memory strobe until mem_ready=1
//   undefined : memory accesses complete in one cycle, mem_ready ignored
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   instr[31:0]         instruction register contents (valid from DECODE)
//   mem_ready           memory handshake (MCC_MEM_WAIT_EN builds only)
//   branch_taken        ALU compare result, sampled in EXEC
//   pc_we, ir_we, rf_we write strobes for PC, IR, register file
//   mem_re, mem_we      memory read / write strobes
//   imm_sel[2:0]        immediate type I=0 S=1 B=2 U=3 J=4
//   alu_src_b           ALU B operand: 0=rs2 1=immediate
//   wb_sel[1:0]         writeback source: 0=ALU 1=memory 2=PC+4
//   pc_sel              next PC: 0=PC+4 1=ALU target
//   illegal             sticky trap flag
//   state[2:0]          current FSM state
//   instret[31:0]       retired-instruction count

module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        pc_we,
    output logic        ir_we,
    output logic        rf_we,
    output logic        mem_re,
    output logic        mem_we,
    output logic [2:0]  imm_sel,
    output logic        alu_src_b,
    output logic [1:0]  wb_sel,
    output logic        pc_sel,
    output logic        illegal,
    output logic [2:0]  state,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH,
        C_LOAD, C_STORE, C_OPIMM, C_OP, C_ILLEGAL
    } class_e;

    state_e      state_q, state_d;
    logic        illegal_q, illegal_d;
    logic [31:0] instret_q, instret_d;

    class_e      cls;
    logic        mem_done;
    logic        pc_we_c, ir_we_c, rf_we_c, mem_re_c, mem_we_c, pc_sel_c;

`ifdef MCC_MEM_WAIT_EN
    logic unused_in;
    assign unused_in = ^instr[31:12];
    assign mem_done  = mem_ready;
`else
    logic unused_in;
    assign unused_in = ^{instr[31:12], mem_ready};
    assign mem_done  = 1'b1;
`endif

    always_comb begin
        cls = C_ILLEGAL;
        case (instr[6:0])
            7'b0110111: cls = C_LUI;
            7'b0010111: cls = C_AUIPC;
            7'b1101111: cls = C_JAL;
            7'b1100111: cls = C_JALR;
            7'b1100011: cls = C_BRANCH;
            7'b0000011: cls = C_LOAD;
            7'b0100011: cls = C_STORE;
            7'b0010011: cls = C_OPIMM;
            7'b0110011: cls = C_OP;
            default:    cls = C_ILLEGAL;
        endcase
    end

    // Next-state and strobe logic
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        instret_d = instret_q;
        pc_we_c   = 1'b0;
        ir_we_c   = 1'b0;
        rf_we_c   = 1'b0;
        mem_re_c  = 1'b0;
        mem_we_c  = 1'b0;
        pc_sel_c  = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_re_c = 1'b1;
                if (mem_done) begin
                    ir_we_c = 1'b1;
                    pc_we_c = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = (cls == C_ILLEGAL) ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                case (cls)
                    C_BRANCH: begin
                        pc_sel_c = 1'b1;
                        pc_we_c  = branch_taken;
                        state_d  = S_FETCH;
                    end
                    C_JAL, C_JALR: begin
                        pc_sel_c = 1'b1;
                        pc_we_c  = 1'b1;
                        state_d  = S_WB;
                    end
                    C_LOAD, C_STORE: state_d = S_MEM;
                    default:         state_d = S_WB;
                endcase
            end
            S_MEM: begin
                mem_re_c = (cls == C_LOAD);
                mem_we_c = (cls == C_STORE);
                if (mem_done) begin
                    state_d = (cls == C_LOAD) ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                rf_we_c = (instr[11:7] != 5'd0);
                state_d = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase

        if (state_d == S_TRAP) begin
            illegal_d = 1'b1;
        end

        // Retirement: any return to FETCH out of an instruction's tail states
        if (state_d == S_FETCH &&
            (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB)) begin
            instret_d = instret_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            instret_q <= instret_d;
        end
    end

    // Strobes are gated with rst_n so they drop the moment reset asserts,
    // even though state_q already reads FETCH during reset.
    assign pc_we  = pc_we_c  & rst_n;
    assign ir_we  = ir_we_c  & rst_n;
    assign rf_we  = rf_we_c  & rst_n;
    assign mem_re = mem_re_c & rst_n;
    assign mem_we = mem_we_c & rst_n;
    assign pc_sel = pc_sel_c & rst_n;

    // Operand selects follow the decoded instruction from DECODE to WB only
    always_comb begin
        imm_sel   = 3'd0;
        alu_src_b = 1'b0;
        wb_sel    = 2'd0;
        if (state_q == S_DECODE || state_q == S_EXEC ||
            state_q == S_MEM    || state_q == S_WB) begin
            case (cls)
                C_LUI, C_AUIPC: imm_sel = 3'd3;
                C_JAL:          imm_sel = 3'd4;
                C_BRANCH:       imm_sel = 3'd2;
                C_STORE:        imm_sel = 3'd1;
                default:        imm_sel = 3'd0;
            endcase
            alu_src_b = !(cls == C_OP || cls == C_BRANCH || cls == C_ILLEGAL);
            case (cls)
                C_LOAD:        wb_sel = 2'd1;
                C_JAL, C_JALR: wb_sel = 2'd2;
                default:       wb_sel = 2'd0;
            endcase
        end
    end

    assign illegal = illegal_q;
    assign state   = state_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl

module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        mem_ready;
    logic        branch_taken;
    logic        pc_we, ir_we, rf_we, mem_re, mem_we;
    logic [2:0]  imm_sel;
    logic        alu_src_b;
    logic [1:0]  wb_sel;
    logic        pc_sel;
    logic        illegal;
    logic [2:0]  state;
    logic [31:0] instret;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .pc_we(pc_we), .ir_we(ir_we),
        .rf_we(rf_we), .mem_re(mem_re), .mem_we(mem_we), .imm_sel(imm_sel),
        .alu_src_b(alu_src_b), .wb_sel(wb_sel), .pc_sel(pc_sel),
        .illegal(illegal), .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       mem_re, mem_we, ir_we, pc_we, rf_we, pc_sel;
        logic [2:0] imm;
        logic       alub;
        logic [1:0] wb;
        logic       ill;
    } obs_t;

    typedef struct {
        logic [31:0] instr;
        logic        taken;
        int          len;
        logic [14:0] path;     // state of cycle k in path[3k +: 3]
        logic [2:0]  imm;
        logic        alub;
        logic [1:0]  wb;
        logic        pcsel_ex;
        logic        pcwe_ex;
        logic [1:0]  memop;    // {we, re} in MEM
        logic        rf;
    } vec_t;

    localparam logic [14:0] P_WB = {3'd0, 3'd4, 3'd2, 3'd1, 3'd0};
    localparam logic [14:0] P_LD = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    localparam logic [14:0] P_ST = {3'd0, 3'd3, 3'd2, 3'd1, 3'd0};
    localparam logic [14:0] P_BR = {3'd0, 3'd0, 3'd2, 3'd1, 3'd0};

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_instret;
    obs_t        sb[$];
    vec_t        tbl[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.st = state;   o.mem_re = mem_re; o.mem_we = mem_we; o.ir_we = ir_we;
        o.pc_we = pc_we; o.rf_we = rf_we;  o.pc_sel = pc_sel; o.imm = imm_sel;
        o.alub = alu_src_b; o.wb = wb_sel; o.ill = illegal;
        return o;
    endfunction

    function automatic obs_t exp_obs(input vec_t v, input logic [2:0] s);
        obs_t o = '0;
        o.st = s;
        if (s != 3'd0) begin
            o.imm = v.imm; o.alub = v.alub; o.wb = v.wb;
        end
        case (s)
            3'd0: begin o.mem_re = 1'b1; o.ir_we = 1'b1; o.pc_we = 1'b1; end
            3'd2: begin o.pc_sel = v.pcsel_ex; o.pc_we = v.pcwe_ex; end
            3'd3: begin o.mem_re = v.memop[0]; o.mem_we = v.memop[1]; end
            3'd4: o.rf_we = v.rf;
            default: ;
        endcase
        return o;
    endfunction

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic sb_check(input string nm);
        obs_t e;
        e = sb.pop_front();
        chk(nm, 64'(sample()), 64'(e));
    endtask

    initial begin
        tbl[0]  = '{32'hF9C30293, 1'b0, 4, P_WB, 3'd0, 1'b1, 2'd0, 1'b0, 1'b0, 2'b00, 1'b1};
        tbl[1]  = '{32'h0C832283, 1'b0, 5, P_LD, 3'd0, 1'b1, 2'd1, 1'b0, 1'b0, 2'b01, 1'b1};
        tbl[2]  = '{32'h00000463, 1'b1, 3, P_BR, 3'd2, 1'b0, 2'd0, 1'b1, 1'b1, 2'b00, 1'b0};
        tbl[3]  = '{32'h00000463, 1'b0, 3, P_BR, 3'd2, 1'b0, 2'd0, 1'b1, 1'b0, 2'b00, 1'b0};
        tbl[4]  = '{32'h0062A023, 1'b0, 4, P_ST, 3'd1, 1'b1, 2'd0, 1'b0, 1'b0, 2'b10, 1'b0};
        tbl[5]  = '{32'h123452B7, 1'b0, 4, P_WB, 3'd3, 1'b1, 2'd0, 1'b0, 1'b0, 2'b00, 1'b1};
        tbl[6]  = '{32'h00000517, 1'b0, 4, P_WB, 3'd3, 1'b1, 2'd0, 1'b0, 1'b0, 2'b00, 1'b1};
        tbl[7]  = '{32'h008000EF, 1'b0, 4, P_WB, 3'd4, 1'b1, 2'd2, 1'b1, 1'b1, 2'b00, 1'b1};
        tbl[8]  = '{32'h000080E7, 1'b0, 4, P_WB, 3'd0, 1'b1, 2'd2, 1'b1, 1'b1, 2'b00, 1'b1};
        tbl[9]  = '{32'h002081B3, 1'b0, 4, P_WB, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b1};
        tbl[10] = '{32'h00000013, 1'b0, 4, P_WB, 3'd0, 1'b1, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0};
        tbl[11] = '{32'h00002003, 1'b0, 5, P_LD, 3'd0, 1'b1, 2'd1, 1'b0, 1'b0, 2'b01, 1'b0};

        rst_n        = 1'b0;
        instr        = 32'h0000_0013;
        branch_taken = 1'b0;
`ifdef MCC_MEM_WAIT_EN
        mem_ready    = 1'b1;
`else
        mem_ready    = 1'b0;   // must be ignored in this build
`endif

        // Reset state
        @(negedge clk);
        #1;
        sb.push_back('0);
        sb_check("reset_outputs");
        chk("reset_instret", 64'(instret), 64'd0);

        // Store aborted by reset during MEM
        rst_n = 1'b1;
        instr = 32'h0062A023;
        #1;
        chk("first_fetch_strobes", 64'({mem_re, ir_we, pc_we}), 64'b111);
        cycle();
        cycle();
        cycle();
        #1;
        chk("store_mem_we", 64'({state, mem_we}), 64'({3'd3, 1'b1}));
        rst_n = 1'b0;
        #1;
        chk("abort_mem_we_drop", 64'({state, mem_we, mem_re}), 64'({3'd0, 1'b0, 1'b0}));
        chk("abort_instret", 64'(instret), 64'd0);
        cycle();
        cycle();
        rst_n = 1'b1;
        #1;
        chk("abort_instret_after", 64'(instret), 64'd0);
        exp_instret = 32'd0;

        // Table-driven instruction vectors
        for (int i = 0; i < 12; i++) begin
            instr        = tbl[i].instr;
            branch_taken = tbl[i].taken;
            for (int k = 0; k < tbl[i].len; k++) begin
                sb.push_back(exp_obs(tbl[i], tbl[i].path[3*k +: 3]));
                if (k > 0) #1;
                sb_check($sformatf("vec%0d_cyc%0d", i, k));
                cycle();
            end
            exp_instret = exp_instret + 32'd1;
            #1;
            chk($sformatf("vec%0d_refetch", i), 64'({state, instret}),
                64'({3'd0, exp_instret}));
        end

`ifdef MCC_MEM_WAIT_EN
        // Fetch stalled by mem_ready
        instr     = 32'h0000_0013;
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall%0d", k), 64'({state, mem_re, ir_we, pc_we}),
                64'({3'd0, 1'b1, 1'b0, 1'b0}));
            cycle();
        end
        mem_ready = 1'b1;
        #1;
        chk("stall_release", 64'({mem_re, ir_we, pc_we}), 64'b111);
        cycle();
        #1;
        chk("stall_decode", 64'(state), 64'd1);
        cycle();
        cycle();
        cycle();
        exp_instret = exp_instret + 32'd1;
        #1;
        chk("stall_retire", 64'({state, instret}), 64'({3'd0, exp_instret}));
`endif

        // Illegal opcode -> TRAP, stays until reset
        instr = 32'hFFFF_FFFF;
        cycle();
        #1;
        chk("trap_decode", 64'({state, illegal}), 64'({3'd1, 1'b0}));
        cycle();
        for (int k = 0; k < 20; k++) begin
            obs_t e;
            e = '0;
            e.st  = 3'd5;
            e.ill = 1'b1;
            sb.push_back(e);
            #1;
            sb_check($sformatf("trap%0d", k));
            cycle();
        end
        chk("trap_instret", 64'(instret), 64'(exp_instret));
        rst_n = 1'b0;
        #1;
        sb.push_back('0);
        sb_check("trap_reset");
        chk("trap_reset_instret", 64'(instret), 64'd0);
        cycle();
        rst_n = 1'b1;
        #1;
        chk("trap_recover", 64'({state, illegal, mem_re}), 64'({3'd0, 1'b0, 1'b1}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
